// File: rtl/fp_serdes.sv
// Byte-serial front end for an external fp_addsub: loads A and B bytes, captures res, streams it back out.
// Optional macro FP_STATUS_EN appends a {nan, inf, zero, sign} status byte after each result.
module fp_serdes #(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_sub,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_sub,
  input  logic [31:0] res,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CAPTURE,
`ifdef FP_STATUS_EN
    STATUS,
`endif
    SEND
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  cnt_inc;
  logic [31:0] result;

  assign cnt_inc = cnt + 2'd1;

  // Bit offset of byte slot c within a 32-bit word, honouring the byte order.
  function automatic logic [4:0] lane(input logic [1:0] c);
    lane = {((LSB_FIRST != 0) ? c : 2'd3 - c), 3'b000};
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] c,
                                           input logic [7:0] b);
    put_byte = w;
    put_byte[lane(c) +: 8] = b;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] c);
    get_byte = w[lane(c) +: 8];
  endfunction

`ifdef FP_STATUS_EN
  logic [7:0] status;
  logic [7:0] flags;
  always_comb begin
    flags = {4'b0000,
             (&res[30:23]) & (|res[22:0]),
             (&res[30:23]) & ~(|res[22:0]),
             ~(|res[30:0]),
             res[31]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      cnt       <= 2'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_sub    <= 1'b0;
      result    <= 32'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
`ifdef FP_STATUS_EN
      status    <= 8'd0;
`endif
    end else begin
      case (state)
        LOAD_A: if (in_valid && in_ready) begin
          op_a <= put_byte(op_a, cnt, in_data);
          cnt  <= cnt_inc;
          if (cnt == 2'd3) state <= LOAD_B;
        end
        LOAD_B: if (in_valid && in_ready) begin
          op_b <= put_byte(op_b, cnt, in_data);
          cnt  <= cnt_inc;
          if (cnt == 2'd3) begin
            op_sub   <= in_sub;
            in_ready <= 1'b0;
            state    <= CAPTURE;
          end
        end
        // res settles from the operands registered on the previous edge.
        CAPTURE: begin
          result    <= res;
          out_data  <= get_byte(res, 2'd0);
          out_valid <= 1'b1;
          state     <= SEND;
`ifdef FP_STATUS_EN
          status    <= flags;
`endif
        end
        SEND: if (out_ready) begin
          cnt <= cnt_inc;
          if (cnt == 2'd3) begin
`ifdef FP_STATUS_EN
            out_data  <= status;
            state     <= STATUS;
`else
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD_A;
`endif
          end else begin
            out_data <= get_byte(result, cnt_inc);
          end
        end
`ifdef FP_STATUS_EN
        STATUS: if (out_ready) begin
          out_data  <= 8'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= LOAD_A;
        end
`endif
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
